// File: rtl/dec8_rr_arbiter.sv
// dec8_rr_arbiter
//   Round-robin arbiter that shares one 8-way resource between 8 requesters.
//   The owner keeps the grant until it releases it. After a release there is
//   one dead GAP cycle and one IDLE cycle, so the decoder output never switches
//   directly from one owner to another. The next arbitration starts searching
//   at the index just after the previous owner.
//
// Ports
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset (release is synchronous to clk)
//   req      [7:0] request vector, req[i] = requester i wants the resource
//   done     release strobe from the current owner (looked at only in GRANT)
//   sel      [2:0] registered owner index, drives the decoder I input
//   En       registered grant valid, drives the decoder En input
//   grant    [7:0] one-hot grant decoded from sel/En
//   busy     high whenever the arbiter is not in IDLE
//   expired  one-cycle pulse on a forced (timeout) release
//
// Optional feature (macro DEC8_ARB_HOLD_TIMEOUT_EN)
//   When the macro is defined, an owner that holds the grant for MAX_HOLD
//   cycles without releasing it is released by force, and expired pulses.
//   When the macro is undefined, a grant is held indefinitely and expired
//   is tied to 0.

module dec8_rr_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] sel,
  output logic       En,
  output logic [7:0] grant,
  output logic       busy,
  output logic       expired
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic [2:0] sel_reg, sel_next;
  logic       en_reg, en_next;
  logic [2:0] ptr_reg, ptr_next;
  logic       release_now;

  // The hold counter is 8 bits wide, so MAX_HOLD must lie in the range 2..255.
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("dec8_rr_arbiter: MAX_HOLD out of range 2..255");
  end

  // Rotating priority search. The loop runs from the lowest priority (k=7)
  // to the highest priority (k=0). A later hit overwrites an earlier one, so
  // the final value is the first request found at or after ptr.
  logic [2:0] pick_idx;
  logic [2:0] probe_idx;
  logic       pick_found;

  always_comb begin
    pick_idx   = ptr_reg;
    pick_found = 1'b0;
    probe_idx  = ptr_reg;
    for (int k = 7; k >= 0; k--) begin
      probe_idx = ptr_reg + 3'(k);
      if (req[probe_idx]) begin
        pick_idx   = probe_idx;
        pick_found = 1'b1;
      end
    end
  end

`ifdef DEC8_ARB_HOLD_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_cnt_reg, hold_cnt_next;
  logic       expired_reg, expired_next;
  logic       timeout;

  // A normal release has priority over a timeout, so expired is raised only
  // when the counter alone forces the release.
  assign timeout = (state_reg == GRANT) && (hold_cnt_reg == HOLD_LAST)
                   && !(done || !req[sel_reg]);
`endif

  always_comb begin
    state_next  = state_reg;
    sel_next    = sel_reg;
    en_next     = en_reg;
    ptr_next    = ptr_reg;
    release_now = 1'b0;
`ifdef DEC8_ARB_HOLD_TIMEOUT_EN
    hold_cnt_next = hold_cnt_reg;
    expired_next  = 1'b0;
`endif
    unique case (state_reg)
      IDLE: begin
        if (pick_found) begin
          sel_next   = pick_idx;
          en_next    = 1'b1;
          state_next = GRANT;
`ifdef DEC8_ARB_HOLD_TIMEOUT_EN
          hold_cnt_next = 8'd0;
`endif
        end
      end
      GRANT: begin
        release_now = done || !req[sel_reg];
`ifdef DEC8_ARB_HOLD_TIMEOUT_EN
        if (timeout) begin
          release_now  = 1'b1;
          expired_next = 1'b1;
        end else if (!release_now) begin
          hold_cnt_next = hold_cnt_reg + 8'd1;
        end
`endif
        if (release_now) begin
          en_next    = 1'b0;
          ptr_next   = sel_reg + 3'd1;   // 3-bit add wraps 7 -> 0
          state_next = GAP;
        end
      end
      GAP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        en_next    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      sel_reg   <= 3'd0;
      en_reg    <= 1'b0;
      ptr_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      en_reg    <= en_next;
      ptr_reg   <= ptr_next;
    end
  end

`ifdef DEC8_ARB_HOLD_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_reg <= 8'd0;
      expired_reg  <= 1'b0;
    end else begin
      hold_cnt_reg <= hold_cnt_next;
      expired_reg  <= expired_next;
    end
  end

  assign expired = expired_reg;
`else
  assign expired = 1'b0;
`endif

  assign sel  = sel_reg;
  assign En   = en_reg;
  assign busy = (state_reg != IDLE);

  // The grant is decoded only from registered sel/En, so it cannot glitch
  // when req changes.
  for (genvar gi = 0; gi < 8; gi++) begin : g_grant
    assign grant[gi] = en_reg & (sel_reg == 3'(gi));
  end

endmodule

// File: tb/tb_dec8_rr_arbiter.sv
module tb_dec8_rr_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [2:0] sel;
  logic       En;
  logic [7:0] grant;
  logic       busy;
  logic       expired;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  dec8_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .sel     (sel),
    .En      (En),
    .grant   (grant),
    .busy    (busy),
    .expired (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the current owner (or -1), the dead cycles still to go
  // before a new arbitration, and the index that has first priority.
  int m_owner;
  int m_bubble;
  int m_pri;
  int m_sel;
  int m_held;
  bit m_exp;

  task automatic model_reset();
    m_owner  = -1;
    m_bubble = 0;
    m_pri    = 0;
    m_sel    = 0;
    m_held   = 0;
    m_exp    = 1'b0;
  endtask

  task automatic model_release();
    m_pri    = (m_owner + 1) % 8;
    m_owner  = -1;
    m_bubble = 1;
  endtask

  task automatic model_step(input logic [7:0] r, input logic d);
    bit found;
    m_exp = 1'b0;
    if (m_owner >= 0) begin
      if (d || !r[m_owner]) begin
        model_release();
      end
`ifdef DEC8_ARB_HOLD_TIMEOUT_EN
      else if (m_held == MAX_HOLD - 1) begin
        model_release();
        m_exp = 1'b1;
      end else begin
        m_held++;
      end
`endif
    end else if (m_bubble > 0) begin
      m_bubble--;
    end else begin
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (!found && r[(m_pri + k) % 8]) begin
          found   = 1'b1;
          m_owner = (m_pri + k) % 8;
        end
      end
      if (found) begin
        m_sel  = m_owner;
        m_held = 0;
      end
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp_v);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("[TB] FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic check_all();
    logic [7:0] g_exp;
    g_exp = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
    check_val("sel",     32'(sel),     32'(m_sel));
    check_val("En",      32'(En),      32'(m_owner >= 0));
    check_val("grant",   32'(grant),   32'(g_exp));
    check_val("busy",    32'(busy),    32'((m_owner >= 0) || (m_bubble > 0)));
    check_val("expired", 32'(expired), 32'(m_exp));
  endtask

  // One clock cycle: drive the inputs, let the edge happen, advance the
  // model, then sample the outputs 1 time unit after the edge.
  task automatic cycle(input logic [7:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    model_step(r, d);
    #1;
    cyc++;
    check_all();
    $display("[TB] cyc %0d req=%h done=%b sel=%0d En=%b grant=%h busy=%b exp=%b",
             cyc, r, d, sel, En, grant, busy, expired);
  endtask

  // Assert reset in the middle of a cycle. The outputs must clear at once,
  // without waiting for a clock edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_val("async_grant", 32'(grant), 32'h0);
    check_val("async_En",    32'(En),    32'h0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] r;
    logic       d;
    rst_n = 1'b0;
    req   = 8'hFF;
    done  = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // The first edge after reset grants requester 0.
    cycle(8'hFF, 1'b0);
    check_val("first_grant", 32'(grant), 32'h01);

    // Every requester is active and each owner releases at once, so the
    // grant rotates 01,02,...,80,01.
    for (int i = 0; i < 30; i++) cycle(8'hFF, 1'b1);

    // Set up ptr=6 by granting and then releasing owner 5. With req=41 the
    // grant must go to 40 first and then wrap to 01.
    for (int i = 0; i < 4; i++) cycle(8'h20, 1'b0);
    cycle(8'h20, 1'b1);
    for (int i = 0; i < 4; i++) cycle(8'h41, 1'b0);
    check_val("ptr6_grant", 32'(grant), 32'h40);
    cycle(8'h41, 1'b1);
    for (int i = 0; i < 3; i++) cycle(8'h41, 1'b0);
    check_val("wrap_grant", 32'(grant), 32'h01);

    // Owner 3 withdraws its request without asserting done.
    for (int i = 0; i < 6; i++) cycle(8'h08, 1'b0);
    for (int i = 0; i < 5; i++) cycle(8'h00, 1'b0);
    for (int i = 0; i < 4; i++) cycle(8'h08, 1'b0);

    // Reset in the middle of a grant to owner 4, then restart with req=30.
    for (int i = 0; i < 5; i++) cycle(8'h10, 1'b0);
    async_reset();
    cycle(8'h30, 1'b0);
    check_val("post_reset_grant", 32'(grant), 32'h10);

    // With no done pulses, a build with the timeout rotates owners 0 and 1.
    // A build without it holds owner 0 throughout.
    for (int i = 0; i < 20; i++) cycle(8'h03, 1'b0);
    cycle(8'h03, 1'b1);

    // Random traffic. req keeps its value for stretches of cycles and done
    // is rare, so long holds still occur.
    r = 8'h00;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) r = 8'($urandom);
      d = ($urandom_range(0, 5) == 0);
      cycle(r, d);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
